// File: rtl/hidden_cpu_sequencer.sv
// rtl/hidden_cpu_sequencer.sv - program buffer and instruction issue sequencer for the HiddenCPU core
module hidden_cpu_sequencer #(
    parameter int              DEPTH     = 16,
    parameter int              AW        = 4,
    parameter int              IW        = 6,
    parameter logic [IW-1:0]   NOP_INSTR = 6'b000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    output logic          load_ready,
    input  logic          start,
    input  logic          halt,
    input  logic          step,
    input  logic          loop_en,
    input  logic          clr,
    output logic          cpu_rst,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   len,
    output logic [7:0]    issue_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_RST = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        DONE    = 3'd4
    } stateType;

    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

    stateType      state;
    stateType      stateNext;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          rstCnt;
    logic          ended;

    logic          loadFire;
    logic          doClr;
    logic          doIssue;
    logic          startRun;
    logic          lastEntry;
    logic [AW:0]   lenNext;

    logic          cpuRstNext;
    logic          busyNext;
    logic          doneNext;
    logic          loadReadyNext;
    logic [IW-1:0] instrNext;
    logic          instrValidNext;

    assign lastEntry = ({1'b0, rdPtr} == (len - (AW+1)'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ended marks that the entry on instr is the program's final one; the run
    // is over, so the next edge retires to DONE whatever halt is doing.
    always_comb begin
        stateNext = state;
        loadFire  = 1'b0;
        doClr     = 1'b0;
        doIssue   = 1'b0;
        startRun  = 1'b0;
        case (state)
            IDLE: begin
                doClr    = clr;
                loadFire = load_valid && load_ready && !clr;
                if (start && !clr && ((len != '0) || loadFire)) begin
                    stateNext = CPU_RST;
                    startRun  = 1'b1;
                end
            end
            CPU_RST: begin
                if (rstCnt) begin
                    stateNext = RUN;
                    doIssue   = 1'b1;
                end
            end
            RUN: begin
                if (ended) begin
                    stateNext = DONE;
                end else if (halt) begin
                    stateNext = PAUSE;
                end else begin
                    doIssue = 1'b1;
                end
            end
            PAUSE: begin
                if (ended) begin
                    stateNext = DONE;
                end else if (start && !halt) begin
                    stateNext = RUN;
                end else if (step && halt) begin
                    doIssue = 1'b1;
                end
            end
            DONE: begin
                if (clr) begin
                    stateNext = IDLE;
                    doClr     = 1'b1;
                end else if (start) begin
                    stateNext = CPU_RST;
                    startRun  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        lenNext = len;
        if (doClr) begin
            lenNext = '0;
        end else if (loadFire) begin
            lenNext = len + (AW+1)'(1);
        end
        cpuRstNext     = (stateNext == CPU_RST);
        busyNext       = (stateNext == CPU_RST) || (stateNext == RUN) || (stateNext == PAUSE);
        doneNext       = (stateNext == DONE);
        loadReadyNext  = (stateNext == IDLE) && (lenNext < FULL_LEN);
        instrNext      = doIssue ? mem[rdPtr] : NOP_INSTR;
        instrValidNext = doIssue;
    end

    always_ff @(posedge clk) begin
        if (!rst && loadFire) begin
            mem[wrPtr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len         <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            rstCnt      <= 1'b0;
            ended       <= 1'b0;
            issue_cnt   <= 8'd0;
            cpu_rst     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_ready  <= 1'b1;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            len <= lenNext;
            if (doClr) begin
                wrPtr <= '0;
            end else if (loadFire) begin
                wrPtr <= wrPtr + AW'(1);
            end

            if (startRun) begin
                rdPtr     <= '0;
                rstCnt    <= 1'b0;
                ended     <= 1'b0;
                issue_cnt <= 8'd0;
            end else begin
                if (state == CPU_RST) begin
                    rstCnt <= 1'b1;
                end
                if (doIssue) begin
                    rdPtr <= lastEntry ? '0 : rdPtr + AW'(1);
                    ended <= lastEntry && !loop_en;
                    if (issue_cnt != 8'hFF) begin
                        issue_cnt <= issue_cnt + 8'd1;
                    end
                end
            end

            cpu_rst     <= cpuRstNext;
            busy        <= busyNext;
            done        <= doneNext;
            load_ready  <= loadReadyNext;
            instr       <= instrNext;
            instr_valid <= instrValidNext;
        end
    end

endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// tb/tb_hidden_cpu_sequencer.sv - directed self-checking bench for hidden_cpu_sequencer
module tb_hidden_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_ready;
    logic       start;
    logic       halt;
    logic       step;
    logic       loop_en;
    logic       clr;
    logic       cpu_rst;
    logic [5:0] instr;
    logic       instr_valid;
    logic       busy;
    logic       done;
    logic [4:0] len;
    logic [7:0] issue_cnt;

    int total = 0;
    int bad   = 0;

    hidden_cpu_sequencer dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .start(start),
        .halt(halt),
        .step(step),
        .loop_en(loop_en),
        .clr(clr),
        .cpu_rst(cpu_rst),
        .instr(instr),
        .instr_valid(instr_valid),
        .busy(busy),
        .done(done),
        .len(len),
        .issue_cnt(issue_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
        halt = 1'b0; step = 1'b0; loop_en = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic loadWord(input logic [5:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        tick();
        total++;
        if ({cpu_rst, busy, done, instr_valid, load_ready} !== 5'b00001) begin
            bad++; $display("FAIL reset_flags got=%b want=00001", {cpu_rst, busy, done, instr_valid, load_ready});
        end
        total++;
        if ({len, issue_cnt, instr} !== 19'd0) begin
            bad++; $display("FAIL reset_values got len=%0d cnt=%0d instr=%h want 0/0/00", len, issue_cnt, instr);
        end
    endtask

    task automatic test_basic_run();
        logic [5:0] prog [3];
        prog[0] = 6'h05; prog[1] = 6'h2A; prog[2] = 6'h3F;
        doReset();
        for (int i = 0; i < 3; i++) loadWord(prog[i]);
        total++;
        if (len !== 5'd3) begin bad++; $display("FAIL basic_len got=%0d want=3", len); end
        pulseStart();
        total++;
        if ({cpu_rst, busy, instr_valid, issue_cnt} !== {3'b110, 8'd0}) begin
            bad++; $display("FAIL basic_cpurst1 got=%b/%0d want=110/0", {cpu_rst, busy, instr_valid}, issue_cnt);
        end
        tick();
        total++;
        if ({cpu_rst, instr_valid} !== 2'b10) begin
            bad++; $display("FAIL basic_cpurst2 got=%b want=10", {cpu_rst, instr_valid});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({cpu_rst, instr_valid, instr, issue_cnt} !== {2'b01, prog[i], 8'(i + 1)}) begin
                bad++; $display("FAIL basic_issue%0d got v=%b instr=%h cnt=%0d want v=1 instr=%h cnt=%0d",
                                i, instr_valid, instr, issue_cnt, prog[i], i + 1);
            end
        end
        tick();
        total++;
        if ({instr_valid, instr, done, busy, issue_cnt} !== {1'b0, 6'h00, 2'b10, 8'd3}) begin
            bad++; $display("FAIL basic_done got v=%b instr=%h done=%b busy=%b cnt=%0d want 0/00/1/0/3",
                            instr_valid, instr, done, busy, issue_cnt);
        end
        pulseStart();
        total++;
        if ({cpu_rst, done, issue_cnt} !== {2'b10, 8'd0}) begin
            bad++; $display("FAIL rerun_start got cpu_rst=%b done=%b cnt=%0d want 1/0/0", cpu_rst, done, issue_cnt);
        end
        tick(); tick();
        total++;
        if ({instr_valid, instr} !== {1'b1, 6'h05}) begin
            bad++; $display("FAIL rerun_first got v=%b instr=%h want 1/05", instr_valid, instr);
        end
        tick(); tick(); tick();
        clr = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0;
        total++;
        if ({busy, done, cpu_rst, load_ready, len} !== {4'b0001, 5'd0}) begin
            bad++; $display("FAIL done_clr_wins got busy=%b done=%b cpu_rst=%b rdy=%b len=%0d want 0/0/0/1/0",
                            busy, done, cpu_rst, load_ready, len);
        end
    endtask

    task automatic test_full_buffer();
        bit sawRst;
        doReset();
        for (int i = 0; i < 16; i++) begin
            loadWord(6'(i + 1));
            if (i == 14) begin
                total++;
                if ({load_ready, len} !== {1'b1, 5'd15}) begin
                    bad++; $display("FAIL full_15 got rdy=%b len=%0d want 1/15", load_ready, len);
                end
            end
        end
        total++;
        if ({load_ready, len} !== {1'b0, 5'd16}) begin
            bad++; $display("FAIL full_16 got rdy=%b len=%0d want 0/16", load_ready, len);
        end
        loadWord(6'h3F);
        total++;
        if (len !== 5'd16) begin bad++; $display("FAIL full_drop got len=%0d want=16", len); end
        pulseStart();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if ({instr_valid, instr} !== {1'b1, 6'(i + 1)}) begin
                bad++; $display("FAIL full_entry%0d got v=%b instr=%h want 1/%h", i, instr_valid, instr, 6'(i + 1));
            end
        end
        tick();
        total++;
        if ({done, instr_valid} !== 2'b10) begin
            bad++; $display("FAIL full_done got done=%b v=%b want 1/0", done, instr_valid);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        loadWord(6'h07);
        total++;
        if (len !== 5'd1) begin bad++; $display("FAIL idle_load got len=%0d want=1", len); end
        clr = 1'b1; load_valid = 1'b1; load_data = 6'h09;
        tick();
        clr = 1'b0; load_valid = 1'b0;
        total++;
        if ({len, load_ready} !== {5'd0, 1'b1}) begin
            bad++; $display("FAIL clr_beats_load got len=%0d rdy=%b want 0/1", len, load_ready);
        end
        pulseStart();
        sawRst = cpu_rst || busy;
        for (int i = 0; i < 4; i++) begin
            tick();
            sawRst = sawRst || cpu_rst || busy;
        end
        total++;
        if (sawRst !== 1'b0) begin bad++; $display("FAIL empty_start got cpu_rst/busy seen=%b want=0", sawRst); end
    endtask

    task automatic test_loop();
        doReset();
        loadWord(6'h11); loadWord(6'h22);
        loop_en = 1'b1;
        pulseStart();
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
            total++;
            if ({instr_valid, instr, issue_cnt} !== {1'b1, ((k % 2) == 0) ? 6'h11 : 6'h22, 8'(k + 1)}) begin
                bad++; $display("FAIL loop_issue%0d got v=%b instr=%h cnt=%0d want 1/%h/%0d",
                                k, instr_valid, instr, issue_cnt, ((k % 2) == 0) ? 6'h11 : 6'h22, k + 1);
            end
        end
        repeat (300) tick();
        total++;
        if ({instr_valid, issue_cnt} !== {1'b1, 8'd255}) begin
            bad++; $display("FAIL loop_saturate got v=%b cnt=%0d want 1/255", instr_valid, issue_cnt);
        end
        loop_en = 1'b0;
        for (int n = 0; n < 4 && !done; n++) tick();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL loop_stop got done=%b want=1 within 4 cycles", done); end
    endtask

    task automatic test_halt_step();
        doReset();
        loadWord(6'h01); loadWord(6'h12); loadWord(6'h23); loadWord(6'h34);
        pulseStart();
        tick(); tick(); tick();
        total++;
        if ({instr_valid, instr} !== {1'b1, 6'h12}) begin
            bad++; $display("FAIL halt_pre got v=%b instr=%h want 1/12", instr_valid, instr);
        end
        halt = 1'b1;
        tick();
        total++;
        if ({instr_valid, instr, busy} !== {1'b0, 6'h00, 1'b1}) begin
            bad++; $display("FAIL halt_nop got v=%b instr=%h busy=%b want 0/00/1", instr_valid, instr, busy);
        end
        tick();
        step = 1'b1; tick(); step = 1'b0;
        total++;
        if ({instr_valid, instr} !== {1'b1, 6'h23}) begin
            bad++; $display("FAIL step1 got v=%b instr=%h want 1/23", instr_valid, instr);
        end
        tick();
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL step1_once got v=%b want=0", instr_valid); end
        step = 1'b1; tick(); step = 1'b0;
        total++;
        if ({instr_valid, instr} !== {1'b1, 6'h34}) begin
            bad++; $display("FAIL step2 got v=%b instr=%h want 1/34", instr_valid, instr);
        end
        tick();
        total++;
        if ({done, instr_valid, issue_cnt} !== {2'b10, 8'd4}) begin
            bad++; $display("FAIL step_done got done=%b v=%b cnt=%0d want 1/0/4", done, instr_valid, issue_cnt);
        end
        halt = 1'b0;
    endtask

    task automatic test_step_start();
        logic [5:0] seen [$];
        doReset();
        loadWord(6'h05); loadWord(6'h0A); loadWord(6'h14); loadWord(6'h28);
        pulseStart();
        tick(); tick();
        halt = 1'b1; tick();
        halt = 1'b0; step = 1'b1; start = 1'b1;
        tick();
        step = 1'b0; start = 1'b0;
        for (int n = 0; n < 8 && !done; n++) begin
            if (instr_valid) seen.push_back(instr);
            tick();
        end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL resume_done got done=%b want=1 within 8 cycles", done); end
        total++;
        if (seen.size() != 3 || seen[0] !== 6'h0A || seen[1] !== 6'h14 || seen[2] !== 6'h28) begin
            bad++; $display("FAIL resume_seq got n=%0d want 3 entries 0A,14,28", seen.size());
        end
        total++;
        if (issue_cnt !== 8'd4) begin bad++; $display("FAIL resume_cnt got=%0d want=4", issue_cnt); end
    endtask

    task automatic test_rst_mid_run();
        doReset();
        loadWord(6'h01); loadWord(6'h02); loadWord(6'h03); loadWord(6'h04);
        pulseStart();
        tick(); tick(); tick(); tick();
        total++;
        if ({instr_valid, instr} !== {1'b1, 6'h03}) begin
            bad++; $display("FAIL mid_pre got v=%b instr=%h want 1/03", instr_valid, instr);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if ({cpu_rst, busy, done, instr_valid, load_ready} !== 5'b00001) begin
            bad++; $display("FAIL mid_rst_flags got=%b want=00001", {cpu_rst, busy, done, instr_valid, load_ready});
        end
        total++;
        if ({len, instr, issue_cnt} !== 19'd0) begin
            bad++; $display("FAIL mid_rst_values got len=%0d instr=%h cnt=%0d want 0/00/0", len, instr, issue_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
        halt = 1'b0; step = 1'b0; loop_en = 1'b0; clr = 1'b0;
        test_reset();
        test_basic_run();
        test_full_buffer();
        test_loop();
        test_halt_step();
        test_step_start();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hidden_cpu_sequencer.md
Name: hidden_cpu_sequencer

Overview:
- Instruction sequencer for the 6-bit-instruction HiddenCPU core.
- Buffers a short program loaded over a valid/ready port, then pulses the core's reset and feeds one instruction per clock into the core's instruction bits.
- Supports free-run, looping, halt/single-step and rerun.
- Sits between the external pin interface and the core; drives the core's reset and opcode/address inputs.

Parameters:
- DEPTH, 16, program buffer entries; power of 2, ≥2.
- AW, 4, pointer width = log2(DEPTH).
- IW, 6, instruction width ({opcode[1:0], addrs[3:0]}).
- NOP_INSTR, 6'b000000, instruction driven whenever instr_valid=0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- load_valid  in  1  load_data valid
- load_data  in  IW  instruction to append to buffer
- load_ready  out  1  buffer accepts a load this cycle
- start  in  1  pulse: begin run (IDLE/DONE) or resume (PAUSE)
- halt  in  1  level: pause issue while in RUN
- step  in  1  pulse: issue one instruction while in PAUSE
- loop_en  in  1  wrap to entry 0 after last entry instead of finishing
- clr  in  1  pulse in DONE/IDLE: empty the buffer
- cpu_rst  out  1  reset to core
- instr  out  IW  instruction to core
- instr_valid  out  1  instr is a program entry, not NOP_INSTR
- busy  out  1  state is CPU_RST, RUN or PAUSE
- done  out  1  state is DONE
- len  out  AW+1  entries loaded, 0..DEPTH
- issue_cnt  out  8  instructions issued since last start, saturates at 255

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On rst: state=IDLE; len, wr_ptr, rd_ptr, issue_cnt = 0; cpu_rst=0; instr_valid=0; instr=NOP_INSTR.
  - Buffer contents are don't-care after rst.
  - rst overrides every other input in any state, mid-run included.
- Registers: all outputs are registered. load_ready = (state==IDLE) && (len<DEPTH); it depends only on registered state.
- IDLE:
  - A load (load_valid && load_ready) writes mem[wr_ptr]; wr_ptr and len increment.
  - Loads while full are dropped.
  - clr sets len and wr_ptr to 0; clr takes priority over a same-cycle load.
  - start with post-load len>0 goes to CPU_RST. A same-cycle load is accepted and counted. start with len==0 is ignored.
- CPU_RST:
  - If start is sampled at edge E, cpu_rst=1 for the two cycles after E; rd_ptr=0, issue_cnt=0.
  - RUN then begins: mem[0] is presented with instr_valid=1 in the third cycle after E.
- RUN:
  - Each cycle presents mem[rd_ptr] with instr_valid=1, increments rd_ptr and increments issue_cnt (saturating).
  - After issuing entry len-1: if loop_en, rd_ptr wraps to 0 and the state stays RUN. Otherwise state goes to DONE, and the following cycle shows instr_valid=0.
  - halt sampled high goes to PAUSE. The entry that would issue next is held and is not skipped.
  - Output in the cycle after halt is sampled is NOP_INSTR with instr_valid=0.
- PAUSE:
  - instr=NOP_INSTR, instr_valid=0.
  - step with halt still high issues exactly one entry for one cycle, with the same pointer/wrap/DONE rules as RUN.
  - start with halt low returns to RUN.
  - If step and start arrive together, start wins.
- DONE:
  - done=1, instr_valid=0; buffer is retained.
  - start goes to CPU_RST and reruns the same program.
  - clr goes to IDLE with len=0. If start and clr arrive together, clr wins.
  - loop_en changes take effect at the next wrap decision.
- Priorities: start/step/clr outside the states named above are ignored. In RUN, halt beats everything.

Test Plan:
- Load 0x05, 0x2A, 0x3F; start at edge 10 -> cpu_rst high cycles 11-12; instr 0x05/0x2A/0x3F valid in cycles 13-15; NOP with done=1 from cycle 16; issue_cnt=3.
- Load 16 entries, then attempt a 17th -> load_ready=0 after 16th, len=16, 17th dropped. start with empty buffer after clr -> state stays IDLE, cpu_rst never asserts.
- 2-entry program, loop_en=1, run 7 issue cycles -> instr sequence A,B,A,B,A,B,A with no NOP gap, issue_cnt=7. Hold 300 cycles -> issue_cnt=255.
- 4-entry program; assert halt after entry 1 issues -> NOP next cycle. Two step pulses -> entries 2 and 3, each valid one cycle, then done=1. No entry skipped or repeated.
- PAUSE; assert step and start in the same cycle with halt low -> resume RUN, the entry issues once and is not double-issued.
- rst asserted mid-RUN at entry 2 -> next cycle state IDLE, len=0, instr_valid=0, cpu_rst=0, load_ready=1.
